// File: rtl/random_array_loader.sv
// random_array_loader
//   Samples a W-bit pseudo-random stream and fills an N-entry array with it.
//   SKIP valid samples are discarded between accepted samples. The finished
//   array is held stable until the next start request.
//
//   Optional build macro: UNIQUE_VALUES_EN. When defined, a sample that
//   matches an entry already written is rejected, so the finished array
//   holds N distinct values.
//
// Ports:
//   clk        in   system clock (posedge)
//   rst        in   synchronous reset, active-low
//   start      in   request a new fill (ignored while filling)
//   rand_in    in   W-bit random value
//   rand_valid in   rand_in valid this cycle
//   array_flat out  N*W packed array; entry i at [i*W +: W]
//   wr_idx     out  entries written so far (0..N)
//   busy       out  high while filling
//   done       out  one-cycle pulse on the cycle the array becomes complete
//   ready      out  high while a complete array is held
module random_array_loader #(
  parameter int N    = 6,
  parameter int W    = 4,
  parameter int SKIP = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [W-1:0]               rand_in,
  input  logic                       rand_valid,
  output logic [N*W-1:0]             array_flat,
  output logic [$clog2(N+1)-1:0]     wr_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       ready
);

  localparam int IW = $clog2(N + 1);
  localparam logic [3:0] SKIP_LD = 4'(SKIP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N*W-1:0]  array_q, array_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [3:0]      skip_q, skip_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  logic [IW-1:0]   idx_inc;
  logic            dup;

  assign idx_inc = wr_idx_q + IW'(1);

`ifdef UNIQUE_VALUES_EN
  // Compare the incoming sample against every entry already written.
  logic [N-1:0] match;
  for (genvar gi = 0; gi < N; gi++) begin : g_match
    assign match[gi] = (IW'(gi) < wr_idx_q) && (array_q[gi*W +: W] == rand_in);
  end
  assign dup = |match;
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    array_d  = array_q;
    wr_idx_d = wr_idx_q;
    skip_d   = skip_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ready_d  = ready_q;

    case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d  = FILL;
          array_d  = '0;
          wr_idx_d = '0;
          skip_d   = SKIP_LD;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end

      FILL: begin
        // start is deliberately not looked at here: a fill runs to completion.
        if (rand_valid) begin
          if (skip_q != 4'd0) begin
            skip_d = skip_q - 4'd1;
          end else begin
            // A rejected duplicate still costs a full skip interval.
            skip_d = SKIP_LD;
            if (!dup) begin
              for (int i = 0; i < N; i++) begin
                if (wr_idx_q == IW'(i)) begin
                  array_d[i*W +: W] = rand_in;
                end
              end
              wr_idx_d = idx_inc;
              if (idx_inc == IW'(N)) begin
                state_d = HOLD;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      array_q  <= '0;
      wr_idx_q <= '0;
      skip_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      array_q  <= array_d;
      wr_idx_q <= wr_idx_d;
      skip_q   <= skip_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign array_flat = array_q;
  assign wr_idx     = wr_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_random_array_loader.sv
// Testbench for random_array_loader. Three instances cover the
// N=6/SKIP=0, N=2/SKIP=2 and N=3/SKIP=0 configurations. Expected arrays are
// pushed to a scoreboard queue when a fill starts and popped when done fires.
module tb_random_array_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=6, SKIP=0
  logic        start_a = 1'b0, valid_a = 1'b0;
  logic [3:0]  rand_a = '0;
  logic [23:0] arr_a;
  logic [2:0]  idx_a;
  logic        busy_a, done_a, ready_a;

  // Instance S: N=2, SKIP=2
  logic        start_s = 1'b0, valid_s = 1'b0;
  logic [3:0]  rand_s = '0;
  logic [7:0]  arr_s;
  logic [1:0]  idx_s;
  logic        busy_s, done_s, ready_s;

  // Instance U: N=3, SKIP=0
  logic        start_u = 1'b0, valid_u = 1'b0;
  logic [3:0]  rand_u = '0;
  logic [11:0] arr_u;
  logic [1:0]  idx_u;
  logic        busy_u, done_u, ready_u;

  random_array_loader #(.N(6), .W(4), .SKIP(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rand_in(rand_a), .rand_valid(valid_a),
    .array_flat(arr_a), .wr_idx(idx_a), .busy(busy_a), .done(done_a), .ready(ready_a));

  random_array_loader #(.N(2), .W(4), .SKIP(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .rand_in(rand_s), .rand_valid(valid_s),
    .array_flat(arr_s), .wr_idx(idx_s), .busy(busy_s), .done(done_s), .ready(ready_s));

  random_array_loader #(.N(3), .W(4), .SKIP(0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .rand_in(rand_u), .rand_valid(valid_u),
    .array_flat(arr_u), .wr_idx(idx_u), .busy(busy_u), .done(done_u), .ready(ready_u));

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    string       name;
    logic [23:0] seq;      // nibble i is presented on the i-th FILL cycle
    logic [23:0] exp_arr;
  } vec_t;
  vec_t vecs[4];

`ifdef UNIQUE_VALUES_EN
  localparam int          U_DONE = 6;
  localparam logic [11:0] U_EXP  = 12'h285;
`else
  localparam int          U_DONE = 3;
  localparam logic [11:0] U_EXP  = 12'h555;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act, input logic act_done);
    logic [31:0] exp;
    chk({name, " done pulse"}, 32'(act_done), 32'd1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h expected an entry", name, act);
    end else begin
      exp = sb_q.pop_front();
      chk({name, " array"}, act, exp);
    end
  endtask

  task automatic fill_a(input string nm, input logic [23:0] seq, input logic [23:0] exp_arr);
    start_a = 1'b1;
    valid_a = 1'b0;
    tick();
    start_a = 1'b0;
    chk({nm, " busy after start"}, 32'(busy_a), 32'd1);
    chk({nm, " ready after start"}, 32'(ready_a), 32'd0);
    chk({nm, " cleared array"}, 32'(arr_a), 32'd0);
    sb_q.push_back({8'h00, exp_arr});
    for (int i = 0; i < 6; i++) begin
      valid_a = 1'b1;
      rand_a  = seq[i*4 +: 4];
      tick();
      chk($sformatf("%s wr_idx %0d", nm, i), 32'(idx_a), 32'(i + 1));
      if (i < 5) chk($sformatf("%s no early done %0d", nm, i), 32'(done_a), 32'd0);
    end
    valid_a = 1'b0;
    sb_check(nm, 32'(arr_a), done_a);
    chk({nm, " busy at done"}, 32'(busy_a), 32'd0);
    chk({nm, " ready at done"}, 32'(ready_a), 32'd1);
    tick();
    chk({nm, " done one cycle"}, 32'(done_a), 32'd0);
    chk({nm, " ready held"}, 32'(ready_a), 32'd1);
    chk({nm, " array held"}, 32'(arr_a), 32'(exp_arr));
  endtask

  initial begin
    logic [3:0] s_seq[6];
    int         s_idx[6];
    logic [3:0] u_seq[6];

    vecs[0] = '{name: "basic",   seq: 24'hDEF739, exp_arr: 24'hDEF739};
    vecs[1] = '{name: "restart", seq: 24'h123456, exp_arr: 24'h123456};
    vecs[2] = '{name: "zeros",   seq: 24'h0A0500, exp_arr: 24'h0A0500};
    vecs[3] = '{name: "allF",    seq: 24'hFFFFFF, exp_arr: 24'hFFFFFF};
    s_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    s_idx = '{0, 0, 1, 1, 1, 2};
    u_seq = '{4'd5, 4'd5, 4'd5, 4'd8, 4'd5, 4'd2};

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("reset array", 32'(arr_a), 32'd0);
    chk("reset wr_idx", 32'(idx_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset ready", 32'(ready_a), 32'd0);
    rst = 1'b1;
    tick();

    // Table-driven fills; each one after the first restarts from HOLD
    for (int v = 0; v < 4; v++) begin
      fill_a(vecs[v].name, vecs[v].seq, vecs[v].exp_arr);
    end

    // Reset mid-fill
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_a = 1'b1;
      rand_a  = 4'(i + 1);
      tick();
    end
    chk("midfill wr_idx before reset", 32'(idx_a), 32'd3);
    rst    = 1'b0;
    rand_a = 4'd4;
    tick();
    chk("midfill reset array", 32'(arr_a), 32'd0);
    chk("midfill reset wr_idx", 32'(idx_a), 32'd0);
    chk("midfill reset busy", 32'(busy_a), 32'd0);
    chk("midfill reset ready", 32'(ready_a), 32'd0);
    rst    = 1'b1;
    rand_a = 4'd7;
    tick();
    tick();
    chk("idle after reset wr_idx", 32'(idx_a), 32'd0);
    chk("idle after reset busy", 32'(busy_a), 32'd0);
    chk("idle after reset array", 32'(arr_a), 32'd0);
    valid_a = 1'b0;
    fill_a("after reset", 24'h654321, 24'h654321);

    // Valid gaps with a start pulse mid-fill that must be ignored
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    sb_q.push_back(32'h00654321);
    for (int i = 0; i <= 10; i++) begin
      valid_a = (i % 2 == 0);
      rand_a  = valid_a ? 4'(i / 2 + 1) : 4'hF;
      start_a = (i == 3);
      tick();
      chk($sformatf("gaps wr_idx %0d", i), 32'(idx_a), 32'(i / 2 + 1));
      if (i < 10) chk($sformatf("gaps no early done %0d", i), 32'(done_a), 32'd0);
    end
    start_a = 1'b0;
    valid_a = 1'b0;
    sb_check("gaps", 32'(arr_a), done_a);

    // Skip decimation: N=2, SKIP=2
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    sb_q.push_back(32'h00000063);
    for (int i = 0; i < 6; i++) begin
      valid_s = 1'b1;
      rand_s  = s_seq[i];
      tick();
      chk($sformatf("skip wr_idx %0d", i), 32'(idx_s), 32'(s_idx[i]));
      if (i < 5) chk($sformatf("skip no early done %0d", i), 32'(done_s), 32'd0);
    end
    valid_s = 1'b0;
    sb_check("skip", 32'(arr_s), done_s);
    chk("skip ready", 32'(ready_s), 32'd1);

    // Duplicate handling: N=3, SKIP=0
    start_u = 1'b1;
    tick();
    start_u = 1'b0;
    sb_q.push_back({20'h0, U_EXP});
    for (int i = 0; i < U_DONE; i++) begin
      valid_u = 1'b1;
      rand_u  = u_seq[i];
      tick();
      if (i < U_DONE - 1) chk($sformatf("uniq no early done %0d", i), 32'(done_u), 32'd0);
    end
    valid_u = 1'b0;
    sb_check("uniq", 32'(arr_u), done_u);
    chk("uniq ready", 32'(ready_u), 32'd1);
    chk("uniq wr_idx", 32'(idx_u), 32'd3);

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/random_array_loader.md
Name: random_array_loader

Overview:
- Downstream consumer of the 4-bit pseudo-random source.
- On a start request, samples the random stream and fills an N-entry array of W-bit values. This is the unsorted data set handed to the sorting engines and the display.
- Holds the completed array stable until the next start.
- Includes a start/busy/done handshake toward the sorting controller.

Parameters:
- N, 6, number of array entries (1..15).
- W, 4, width of each entry; must equal the random source width.
- SKIP, 2, number of valid random samples discarded between accepted samples. Decorrelates successive shift-register outputs; range 0..15.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- start  input  1  request a new fill; sampled on posedge.
- rand_in  input  W  random value from the source.
- rand_valid  input  1  rand_in is valid this cycle; tie high for a free-running source.
- array_flat  output  N*W  entry i at bits [i*W +: W]; entry 0 is the LSBs.
- wr_idx  output  ceil(log2(N+1))  number of entries written so far.
- busy  output  1  high while filling.
- done  output  1  one-cycle pulse when the last entry is written.
- ready  output  1  level; high while a complete array is held.

Behaviour:
- Reset (posedge clk with rst=0):
  - State returns to IDLE.
  - array_flat=0, wr_idx=0, busy=0, done=0, ready=0, skip counter=0.
  - Reset takes priority over all other inputs, including mid-fill; a partial array is discarded.
- States: IDLE, FILL, HOLD.
- IDLE:
  - start=1 -> FILL next cycle.
  - On that transition: array_flat cleared to 0, wr_idx=0, skip counter loaded with SKIP, busy=1.
- FILL, on each rand_valid=1 cycle:
  - skip counter != 0: decrement it, nothing is written.
  - skip counter == 0: write rand_in to entry wr_idx, increment wr_idx, reload skip counter with SKIP.
  - The write is visible on array_flat the cycle after acceptance.
- FILL, rand_valid=0 cycles: no change; the skip counter holds.
- Completion: when the write brings wr_idx to N:
  - Transition to HOLD.
  - done=1 for exactly that one cycle, with array_flat already holding all N entries.
  - busy=0 and ready=1 from that same cycle.
- HOLD:
  - array_flat and wr_idx held.
  - start=1 -> same action as from IDLE (clear, busy=1, ready=0) and back to FILL.
- start while in FILL is ignored; it does not restart the fill.
- With SKIP=0 and rand_valid held high, the first write occurs on the first FILL cycle and done asserts N cycles after start is sampled.
  - Example: start sampled at edge 0 -> entries written at edges 1..N -> done high after edge N.
- General fill latency: N*(SKIP+1) valid cycles.
- wr_idx never exceeds N; there are no writes outside FILL.
- rand_in is captured exactly as presented, including the value 0; no range remapping.

Optional Feature:
- Macro: UNIQUE_VALUES_EN.
- Defined: in FILL, an otherwise-accepted sample whose value equals any entry already written (index < wr_idx) is rejected.
  - A rejected sample causes no write and no wr_idx change.
  - The skip counter is reloaded with SKIP as if the sample had been accepted.
  - The comparison is combinational against the written entries in the same cycle.
  - The guaranteed array contains N distinct values. N must be <= the number of distinct values the source produces (15 for a maximal 4-bit source); otherwise the fill never completes.
- Undefined: no comparison logic is built and duplicates are stored.

Test Plan:
- Reset mid-fill: N=6, SKIP=0, start, then rst=0 after 3 writes -> next cycle array_flat=0, wr_idx=0, busy=0, ready=0, state IDLE; a later start fills from entry 0.
- Basic fill: N=6, SKIP=0, rand_valid=1, rand_in sequence 9,3,7,15,14,13 from the first FILL cycle -> array_flat=24'hDEF739, done pulses for exactly 1 cycle after the 6th write, ready=1, busy=0.
- Skip decimation: N=2, SKIP=2, rand_in 1,2,3,4,5,6 on consecutive valid cycles -> entries = 3,6; done after 6 valid cycles.
- Valid gaps and ignored start: SKIP=0, rand_valid toggling 1,0,1,0..., start pulsed mid-fill -> only valid-cycle values stored, wr_idx advances on valid cycles only, fill not restarted.
- Restart from HOLD: after a completed fill, pulse start -> array_flat=0 and ready=0 on the next cycle, new values written, done pulses again.
- UNIQUE_VALUES_EN: N=3, SKIP=0, rand_in 5,5,5,8,5,2 -> entries 5,8,2; done after the 6th valid cycle. With the macro undefined, the same input gives 5,5,5.
